// File: rtl/fpu_cvt_arbiter.sv
// fpu_cvt_arbiter: shares one fixed-latency, non-stallable int32->float32 conversion
// unit between two requesters.
//
// Issue side uses round-robin arbitration on valid/ready. A LAT-deep {vld, tag}
// pipeline tracks which requester owns each in-flight op. Write-back goes into a
// per-requester result FIFO. Issue is credit-gated so a write-back never finds its
// FIFO full, which means results survive any response backpressure.
//
// Parameters:
//   LAT   - latency of the shared unit (operand in cycle t, result in cycle t+LAT)
//   DEPTH - entries per result FIFO and initial credits per requester (>= 1)
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req{0,1}_valid/ready/x        issue handshake and int32 operand per requester
//   unit_x / unit_y               operand to / result from the shared unit
//   rsp{0,1}_valid/ready/y        result handshake and float32 result per requester
//   busy                          op in flight or result stored
//
// Optional: define FPU_ARB_STATS_EN to add the stat_* counters (issue counts,
// dual-valid cycles, cycles blocked by missing credit).

module fpu_cvt_arbiter #(
  parameter int unsigned LAT   = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  output logic [31:0] unit_x,
  input  logic [31:0] unit_y,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_y,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_y,
  output logic        busy
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [31:0] stat_issue0,
  output logic [31:0] stat_issue1,
  output logic [31:0] stat_conflict,
  output logic [31:0] stat_nocredit
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [1:0]    req_valid;
  logic [1:0]    rsp_ready;
  logic [1:0]    elig;
  logic [1:0]    grant;
  logic [1:0]    wr;
  logic [1:0]    pop;
  logic [1:0]    empty;

  logic          rr_q;          // 0: requester 0 preferred on conflict
  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] tag_q;
  logic [CW-1:0] credit_q [2];
  logic [CW-1:0] count_q  [2];
  logic [PW-1:0] wptr_q   [2];
  logic [PW-1:0] rptr_q   [2];
  logic [31:0]   mem_q    [2][DEPTH];

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  always_comb begin
    grant = 2'b00;
    for (int i = 0; i < 2; i++) begin
      elig[i]  = req_valid[i] && (credit_q[i] != '0);
      empty[i] = (count_q[i] == '0);
      pop[i]   = !empty[i] && rsp_ready[i];
    end
    // Ready is masked during reset so the handshake outputs read zero.
    if (!rst) begin
      if (elig[0] && (!elig[1] || !rr_q)) grant[0] = 1'b1;
      else if (elig[1])                   grant[1] = 1'b1;
    end
    wr[0] = vld_q[LAT-1] && !tag_q[LAT-1];
    wr[1] = vld_q[LAT-1] &&  tag_q[LAT-1];
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign unit_x     = grant[0] ? req0_x : (grant[1] ? req1_x : 32'h0);

  assign rsp0_valid = !empty[0];
  assign rsp1_valid = !empty[1];
  assign rsp0_y     = empty[0] ? 32'h0 : mem_q[0][rptr_q[0]];
  assign rsp1_y     = empty[1] ? 32'h0 : mem_q[1][rptr_q[1]];
  assign busy       = (|vld_q) || !empty[0] || !empty[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q  <= 1'b0;
      vld_q <= '0;
      tag_q <= '0;
      for (int i = 0; i < 2; i++) begin
        credit_q[i] <= CW'(DEPTH);
        count_q[i]  <= '0;
        wptr_q[i]   <= '0;
        rptr_q[i]   <= '0;
      end
    end else begin
      if (grant[0])      rr_q <= 1'b1;
      else if (grant[1]) rr_q <= 1'b0;

      vld_q[0] <= |grant;
      tag_q[0] <= grant[1];
      for (int k = 1; k < LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end

      for (int i = 0; i < 2; i++) begin
        if (grant[i] && !pop[i])      credit_q[i] <= credit_q[i] - 1'b1;
        else if (pop[i] && !grant[i]) credit_q[i] <= credit_q[i] + 1'b1;

        if (wr[i] && !pop[i])      count_q[i] <= count_q[i] + 1'b1;
        else if (pop[i] && !wr[i]) count_q[i] <= count_q[i] - 1'b1;

        if (wr[i])  wptr_q[i] <= (wptr_q[i] == PW'(DEPTH - 1)) ? '0 : wptr_q[i] + 1'b1;
        if (pop[i]) rptr_q[i] <= (rptr_q[i] == PW'(DEPTH - 1)) ? '0 : rptr_q[i] + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr[i]) mem_q[i][wptr_q[i]] <= unit_y;
    end
  end

  // Credits bound in-flight plus stored ops, so a write-back can never hit a full FIFO.
  assert property (@(posedge clk) disable iff (rst) !(wr[0] && count_q[0] == CW'(DEPTH)));
  assert property (@(posedge clk) disable iff (rst) !(wr[1] && count_q[1] == CW'(DEPTH)));

`ifdef FPU_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issue0   <= '0;
      stat_issue1   <= '0;
      stat_conflict <= '0;
      stat_nocredit <= '0;
    end else begin
      if (grant[0]) stat_issue0 <= stat_issue0 + 32'd1;
      if (grant[1]) stat_issue1 <= stat_issue1 + 32'd1;
      if (req0_valid && req1_valid) stat_conflict <= stat_conflict + 32'd1;
      if ((req0_valid && credit_q[0] == '0) || (req1_valid && credit_q[1] == '0)) begin
        stat_nocredit <= stat_nocredit + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fpu_cvt_arbiter.sv
// Bench for fpu_cvt_arbiter: models the shared conversion unit as a LAT-stage pipe,
// applies a table of single ops, then hand-written contention, backpressure,
// credit-stream and mid-operation reset sequences.

module tb_fpu_cvt_arbiter;

  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_x = '0, req1_x = '0;
  logic [31:0] unit_x, unit_y;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp0_y, rsp1_y;
  logic        busy;
`ifdef FPU_ARB_STATS_EN
  logic [31:0] stat_issue0, stat_issue1, stat_conflict, stat_nocredit;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] pipe [LAT];

  fpu_cvt_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x     (req0_x),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x     (req1_x),
    .unit_x     (unit_x),
    .unit_y     (unit_y),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_y     (rsp0_y),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_y     (rsp1_y),
    .busy       (busy)
`ifdef FPU_ARB_STATS_EN
    ,
    .stat_issue0   (stat_issue0),
    .stat_issue1   (stat_issue1),
    .stat_conflict (stat_conflict),
    .stat_nocredit (stat_nocredit)
`endif
  );

  always #5 clk = ~clk;

  // int32 -> float32, round to nearest even.
  function automatic logic [31:0] i2f(input logic [31:0] x);
    logic        s;
    logic [31:0] mag;
    logic [63:0] m, rem, half;
    int          p, e, sh;
    s   = x[31];
    mag = s ? (~x + 32'd1) : x;
    if (mag == 32'd0) return 32'h0;
    p = 0;
    for (int k = 0; k < 32; k++) if (mag[k]) p = k;
    e = 127 + p;
    if (p <= 23) begin
      m = {32'd0, mag} << (23 - p);
    end else begin
      sh   = p - 23;
      m    = {32'd0, mag} >> sh;
      rem  = {32'd0, mag} & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 64'd1;
      if (m == (64'd1 << 24)) begin
        m = m >> 1;
        e = e + 1;
      end
    end
    return {s, 8'(e), m[22:0]};
  endfunction

  // Shared-unit model: result appears LAT cycles after the operand.
  always @(posedge clk) begin
    pipe[0] <= i2f(unit_x);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign unit_y = pipe[LAT-1];

  // Collect every accepted response in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp0_valid && rsp0_ready) q0.push_back(rsp0_y);
      if (rsp1_valid && rsp1_ready) q1.push_back(rsp1_y);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  typedef struct {
    logic        req;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  vec_t vecs [10];
  int   first, n0, n1, n0_blk, outst, nsim, bad;
  logic [31:0] got;
  logic [31:0] vals [5];
  logic exp_rdy, iss, pp;

  initial begin
    vecs[0] = '{1'b0, 32'd5,        32'h40A00000};
    vecs[1] = '{1'b1, 32'hFFFFFFFF, 32'hBF800000};
    vecs[2] = '{1'b0, 32'h01000001, 32'h4B800000};
    vecs[3] = '{1'b1, 32'd0,        32'h00000000};
    vecs[4] = '{1'b0, 32'd1,        32'h3F800000};
    vecs[5] = '{1'b1, 32'h80000000, 32'hCF000000};
    vecs[6] = '{1'b0, 32'h7FFFFFFF, 32'h4F000000};
    vecs[7] = '{1'b1, 32'd3,        32'h40400000};
    vecs[8] = '{1'b1, 32'hFFFFFFFE, 32'hC0000000};
    vecs[9] = '{1'b0, 32'd7,        32'h40E00000};
    vals[0] = 32'd1; vals[1] = 32'd2; vals[2] = 32'd3; vals[3] = 32'd4; vals[4] = 32'd5;

    // Reset state, with both requesters asking.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_x     = 32'd11;
    @(negedge clk);
    check("reset_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    check("reset_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    check("reset_unit_x", unit_x, 32'd0);
    check("reset_rsp_y", rsp0_y | rsp1_y, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    do_reset();

    // Single ops from the table: latency, value, idle afterwards.
    for (int v = 0; v < 10; v++) begin
      drive_edge();
      if (vecs[v].req) begin req1_valid = 1'b1; req1_x = vecs[v].x; end
      else             begin req0_valid = 1'b1; req0_x = vecs[v].x; end
      @(negedge clk);
      check($sformatf("vec%0d_ready", v), {31'd0, vecs[v].req ? req1_ready : req0_ready}, 32'd1);
      check($sformatf("vec%0d_unit_x", v), unit_x, vecs[v].x);
      first = -1;
      got   = 32'h0;
      for (int c = 1; c <= int'(LAT) + 4; c++) begin
        drive_edge();
        if (c == 1) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        @(negedge clk);
        if (first < 0 && (vecs[v].req ? rsp1_valid : rsp0_valid)) begin
          first = c;
          got   = vecs[v].req ? rsp1_y : rsp0_y;
        end
      end
      check($sformatf("vec%0d_latency", v), first, LAT + 1);
      check($sformatf("vec%0d_y", v), got, vecs[v].y);
      check($sformatf("vec%0d_busy_after", v), {31'd0, busy}, 32'd0);
    end

    // Contention: grants alternate starting with requester 0.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive_edge();
      req0_valid = 1'b1; req0_x = 32'hFFFFFFFF;
      req1_valid = 1'b1; req1_x = 32'h01000001;
      @(negedge clk);
      check($sformatf("contention_grant%0d", k), {30'd0, req0_ready, req1_ready},
            (k % 2 == 0) ? 32'd2 : 32'd1);
    end
    drive_edge();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("contention_cnt0", q0.size(), 32'd4);
    check("contention_cnt1", q1.size(), 32'd4);
    bad = 0;
    foreach (q0[i]) if (q0[i] !== 32'hBF800000) bad++;
    foreach (q1[i]) if (q1[i] !== 32'h4B800000) bad++;
    check("contention_values_bad", bad, 32'd0);

    // Backpressure on requester 1: credit exhaustion, then one pop re-enables one issue.
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b0;
    n0 = 0; n1 = 0; n0_blk = 0;
    for (int c = 0; c < 14; c++) begin
      drive_edge();
      req0_valid = 1'b1; req0_x = 32'd7;
      req1_valid = 1'b1;
      if (n1 < 5) req1_x = vals[n1];
      @(negedge clk);
      if (req1_ready) n1++;
      if (req0_ready) begin
        n0++;
        if (n1 == 4) n0_blk++;
      end
    end
    check("bp_req1_issues", n1, 32'd4);
    check("bp_req1_blocked", {31'd0, req1_ready}, 32'd0);
    check("bp_req0_served", {31'd0, n0_blk > 0}, 32'd1);
    drive_edge();
    req0_valid = 1'b0;
    @(negedge clk);
    check("bp_still_blocked", {31'd0, req1_ready}, 32'd0);
    drive_edge();
    rsp1_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_valid", {31'd0, rsp1_valid}, 32'd1);
    check("bp_pop_y", rsp1_y, 32'h3F800000);
    check("bp_pop_no_bypass", {31'd0, req1_ready}, 32'd0);
    drive_edge();
    rsp1_ready = 1'b0;
    req1_x = vals[4];
    @(negedge clk);
    check("bp_reissue", {31'd0, req1_ready}, 32'd1);
    drive_edge();
    @(negedge clk);
    check("bp_one_only", {31'd0, req1_ready}, 32'd0);
    drive_edge();
    req1_valid = 1'b0;
    rsp1_ready = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("bp_q1_cnt", q1.size(), 32'd5);
    bad = 0;
    foreach (q1[i]) if (i < 5 && q1[i] !== i2f(vals[i])) bad++;
    check("bp_q1_order_bad", bad, 32'd0);
    check("bp_q0_cnt", q0.size(), n0);
    bad = 0;
    foreach (q0[i]) if (q0[i] !== 32'h40E00000) bad++;
    check("bp_q0_values_bad", bad, 32'd0);

    // Requester 0 stream against a credit model; covers issue+pop at credit 1.
    do_reset();
    n0 = 0; outst = 0; nsim = 0;
    for (int c = 0; c < 30; c++) begin
      drive_edge();
      req0_valid = 1'b1;
      req0_x     = n0 + 1;
      @(negedge clk);
      exp_rdy = (int'(DEPTH) - outst) > 0;
      check($sformatf("stream_ready%0d", c), {31'd0, req0_ready}, {31'd0, exp_rdy});
      iss = req0_ready;
      pp  = rsp0_valid && rsp0_ready;
      if (iss && pp && (int'(DEPTH) - outst) == 1) nsim++;
      outst = outst + int'(iss) - int'(pp);
      if (iss) n0++;
    end
    drive_edge();
    req0_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("stream_sim_at_credit1", {31'd0, nsim > 0}, 32'd1);
    check("stream_cnt", q0.size(), n0);
    bad = 0;
    foreach (q0[i]) if (q0[i] !== i2f(i + 1)) bad++;
    check("stream_order_bad", bad, 32'd0);

    // Reset with three ops in flight.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive_edge();
      req0_valid = 1'b1;
      req0_x     = 32'd9;
    end
    @(posedge clk);
    #1;
    check("midrst_busy_before", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    check("midrst_outputs", unit_x | rsp0_y | rsp1_y, 32'd0);
    check("midrst_flags", {29'd0, rsp0_valid, rsp1_valid, busy}, 32'd0);
    req0_valid = 1'b0;
    drive_edge();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < int'(LAT) + 2; c++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) bad++;
    end
    check("midrst_no_stale", bad, 32'd0);
    rsp0_ready = 1'b0;
    n0 = 0;
    for (int c = 0; c < 6; c++) begin
      drive_edge();
      req0_valid = 1'b1;
      req0_x     = 32'd2;
      @(negedge clk);
      if (req0_ready) n0++;
    end
    check("midrst_credits", n0, DEPTH);
    drive_edge();
    req0_valid = 1'b0;
    rsp0_ready = 1'b1;
    repeat (10) @(posedge clk);

`ifdef FPU_ARB_STATS_EN
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive_edge();
      req0_valid = 1'b1; req0_x = 32'd1;
      req1_valid = 1'b1; req1_x = 32'd2;
    end
    drive_edge();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("stat_conflict", stat_conflict, 32'd10);
    check("stat_issue0", stat_issue0, 32'd5);
    check("stat_issue1", stat_issue1, 32'd5);
    check("stat_nocredit", stat_nocredit, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_cvt_arbiter.md
Name: fpu_cvt_arbiter

Overview:
- Shares one fixed-latency, non-stallable pipelined conversion unit (fcvt_s_w-class, int32 -> float32) between two requesters.
- Round-robin issue arbitration on valid/ready, with an in-flight tag pipeline that tracks which requester owns each operation.
- Per-requester result FIFOs with credit-based issue, so results are never dropped under response backpressure.
- Sits between the core's FPU dispatch / second client and the conversion datapath.

Parameters:
- LAT, 4, pipeline latency of the shared unit in cycles: operand on unit_x in cycle t, result on unit_y in cycle t+LAT.
- DEPTH, 4, entries per requester result FIFO; also the initial credit count per requester (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req0_valid  in  1  requester 0 operand valid
- req0_ready  out  1  requester 0 issue accepted this cycle
- req0_x  in  32  requester 0 signed int32 operand
- req1_valid / req1_ready / req1_x  in/out/in  1/1/32  same for requester 1
- unit_x  out  32  operand to shared unit
- unit_y  in  32  result from shared unit
- rsp0_valid  out  1  requester 0 result available
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_y  out  32  requester 0 float32 result (FIFO head)
- rsp1_valid / rsp1_ready / rsp1_y  out/in/out  1/1/32  same for requester 1
- busy  out  1  any op in flight or any FIFO non-empty

Behaviour:
- Reset (async, rst=1):
  - RR pointer = 0, so requester 0 is preferred first.
  - All in-flight valid bits cleared; both FIFOs emptied; credits = DEPTH each.
  - Outputs: req*_ready=0, rsp*_valid=0, rsp*_y=0, unit_x=0, busy=0.
- Eligibility: requester i is eligible iff reqi_valid=1 and credit_i>0.
- Grant:
  - At most one grant per cycle.
  - If both requesters are eligible, grant the one the RR pointer prefers.
  - If only one is eligible, grant it.
- Handshake:
  - reqi_ready = grant_i, combinational from reqi_valid and state.
  - Issue occurs in the cycle where valid=1 and ready=1.
  - Requesters hold reqi_x stable while valid=1 and ready=0.
- RR pointer: after any grant, points to the non-granted requester; unchanged when there is no grant.
- unit_x = granted operand in the issue cycle, else 32'h0.
- Tag pipeline: LAT-stage shift register of {vld, tag}. Stage 0 is loaded each cycle with {issue, granted id}.
- Write-back: when the last stage has vld=1, unit_y is written into FIFO[tag] at the end of cycle t+LAT.
- Response timing:
  - rspi_valid = FIFO_i non-empty; rspi_y = head entry.
  - Pop on rspi_valid & rspi_ready.
  - Minimum latency from issue cycle to rsp_valid is LAT+1 cycles.
  - Results to one requester are returned in issue order.
- Credits:
  - Issue to i decrements credit_i; pop from i increments it.
  - Simultaneous issue and pop on the same requester leaves credit_i unchanged.
  - credit_i never exceeds DEPTH and never underflows.
  - In-flight + stored ops per requester <= DEPTH, so a FIFO write never finds the FIFO full. The implementation asserts this in simulation.
- FIFO boundaries:
  - Write and pop in the same cycle on a full FIFO cannot occur, because credits prevent it.
  - On an empty FIFO, a write and a pop in the same cycle do not bypass: rsp_valid rises the next cycle.
  - Pointers wrap modulo DEPTH.
- Credit exhaustion: credit_i=0 forces reqi_ready=0 regardless of RR. The other requester may still issue every cycle.
- Reset mid-operation: in-flight ops are discarded, because vld is cleared. The shared unit's pipeline contents are ignored thereafter.
- busy = OR(vld stages) | ~empty0 | ~empty1.

Optional Feature:
- Macro: FPU_ARB_STATS_EN.
- With the macro defined, the block adds these outputs, all cleared by rst:
  - stat_issue0 [31:0]: ops issued by requester 0.
  - stat_issue1 [31:0]: ops issued by requester 1.
  - stat_conflict [31:0]: cycles where both requesters were valid.
  - stat_nocredit [31:0]: cycles where some reqi_valid=1 with credit_i=0.
- Counters wrap at 2^32.
- Without the macro, these ports and their logic are absent and all other behaviour is identical.

Test Plan:
- Single op: req0_x=5 issued at cycle 0, rsp0_ready=1 -> rsp0_valid at cycle LAT+1=5 with rsp0_y=0x40A00000; busy low afterwards.
- Contention: both valid continuously, req0_x=-1, req1_x=0x01000001 -> grants alternate 0,1,0,1 starting with 0. rsp0_y=0xBF800000 and rsp1_y=0x4B800000 (rounded), each in its own issue order.
- Backpressure: rsp1_ready=0, req1 valid each cycle with 1,2,3,4,5 -> exactly DEPTH=4 issues accepted, then req1_ready=0. The first pop (0x3F800000) re-enables one issue the next cycle. Requester 0 remains serviced throughout.
- Simultaneous issue and pop on requester 0 at credit 1 -> credit stays 1 and a back-to-back stream is sustained with no lost results.
- Reset asserted with 3 ops in flight -> all outputs zero immediately. After release, no stale rsp_valid appears within LAT+2 cycles, and credits = DEPTH.
- With FPU_ARB_STATS_EN: 10 cycles of dual valid -> stat_conflict=10, stat_issue0=5, stat_issue1=5.
